sw_input_port: RTL



---
 rtl/sw_input_port_pkg.sv | 35 +++
 rtl/sw_input_port_debounce_sync.sv | 65 ++++++
 rtl/sw_input_port.sv | 113 +++++++++++
 3 files changed

// File: rtl/sw_input_port_pkg.sv
// Shared definitions for the switch/button input port: register indices,
// status-word bit positions and a helper that packs the status word.
package sw_input_port_pkg;

    localparam int SW_W      = 16;
    localparam int BTN_CNT_W = 8;

    // Word index of each register (CPU byte address bits [3:2]).
    typedef enum logic [1:0] {
        SWIN_DATA = 2'd0,
        SWIN_STAT = 2'd1,
        SWIN_MASK = 2'd2,
        SWIN_RSVD = 2'd3
    } swin_reg_e;

    // Bit positions inside the status word (SWIN_STAT).
    localparam int STAT_BTN_BIT = 0;
    localparam int STAT_CHG_BIT = 1;
    localparam int STAT_CNT_LSB = 2;
    localparam int STAT_CNT_MSB = STAT_CNT_LSB + BTN_CNT_W - 1;

    // Packs button count, change flag and button level into the status word;
    // every bit not named here reads as zero.
    function automatic logic [31:0] stat_word(input logic [BTN_CNT_W-1:0] cnt,
                                              input logic                 chg,
                                              input logic                 btn);
        logic [31:0] w;
        w                            = '0;
        w[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
        w[STAT_CHG_BIT]              = chg;
        w[STAT_BTN_BIT]              = btn;
        return w;
    endfunction

endpackage

// File: rtl/sw_input_port_debounce_sync.sv
// Two-flop synchronizer followed by a whole-vector debouncer. A new value is
// accepted only after DEBOUNCE_CYCLES consecutive identical synchronized
// samples; the vector is always updated as a unit, never bit by bit.
module debounce_sync #(
    parameter int W               = 1,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] stable_o,
    output logic [W-1:0] cand_o,
    output logic         accept_o
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     meta_q;
    logic [W-1:0]     sync_q;
    logic [W-1:0]     cand_q,   cand_d;
    logic [W-1:0]     stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             accept;

    // Debounce decision: restart on any difference, count while equal,
    // promote the candidate once the count has saturated.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cand_q != stable_q) begin
            stable_d = cand_q;
            accept   = 1'b1;
        end
    end

    // Synchronizer chain and debounce state; reset discards any pending candidate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q   <= '0;
            sync_q   <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            meta_q   <= async_i;
            sync_q   <= meta_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign cand_o   = cand_q;
    assign accept_o = accept;

endmodule

// File: rtl/sw_input_port.sv
// Read-only memory-mapped input port: debounced switches and push button,
// a sticky change flag with per-bit change mask, a press counter, and a
// level interrupt that mirrors the change flag.
import sw_input_port_pkg::*;

module sw_input_port #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter bit IRQ_EN          = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] sw_i,
    input  logic        btn_i,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        irq
);

    logic [SW_W-1:0]      sw_stable;
    logic [SW_W-1:0]      sw_cand;
    logic                 sw_accept;
    logic [0:0]           btn_stable;
    logic [0:0]           btn_cand;
    logic                 btn_accept;

    logic                 sw_changed_q, sw_changed_d;
    logic [SW_W-1:0]      chg_mask_q,   chg_mask_d;
    logic [BTN_CNT_W-1:0] btn_count_q,  btn_count_d;
    logic [31:0]          rd_data_q,    rd_data_d;
    logic                 rd_valid_q;
    logic [31:0]          rd_word;
    logic                 clr_changed;
    logic                 clr_mask;

    debounce_sync #(
        .W               (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk_i    (CLK),
        .rst_i    (RST),
        .async_i  (sw_i),
        .stable_o (sw_stable),
        .cand_o   (sw_cand),
        .accept_o (sw_accept)
    );

    debounce_sync #(
        .W               (1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk_i    (CLK),
        .rst_i    (RST),
        .async_i  (btn_i),
        .stable_o (btn_stable),
        .cand_o   (btn_cand),
        .accept_o (btn_accept)
    );

    // Register read mux, built from the contents before any read side effect.
    always_comb begin
        rd_word = '0;
        case (swin_reg_e'(addr))
            SWIN_DATA: rd_word = {16'b0, sw_stable};
            SWIN_STAT: rd_word = stat_word(btn_count_q, sw_changed_q, btn_stable[0]);
            SWIN_MASK: rd_word = {16'b0, chg_mask_q};
            default:   rd_word = '0;
        endcase
    end

    // Next state for flags, mask, press counter and read data. Clears from a
    // read are applied first so a coincident accept overrides them: the flag
    // stays set and the mask keeps only the newly changed bits.
    always_comb begin
        clr_changed  = rd_en && (swin_reg_e'(addr) == SWIN_DATA);
        clr_mask     = rd_en && (swin_reg_e'(addr) == SWIN_MASK);
        sw_changed_d = clr_changed ? 1'b0 : sw_changed_q;
        chg_mask_d   = clr_mask ? '0 : chg_mask_q;
        if (sw_accept) begin
            sw_changed_d = 1'b1;
            chg_mask_d   = chg_mask_d | (sw_cand ^ sw_stable);
        end
        // An accept always flips the button level, so cand=1 marks a press.
        btn_count_d = btn_count_q;
        if (btn_accept && btn_cand[0]) begin
            btn_count_d = btn_count_q + BTN_CNT_W'(1);
        end
        rd_data_d = rd_en ? rd_word : rd_data_q;
    end

    // Status and bus-side registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_changed_q <= 1'b0;
            chg_mask_q   <= '0;
            btn_count_q  <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            sw_changed_q <= sw_changed_d;
            chg_mask_q   <= chg_mask_d;
            btn_count_q  <= btn_count_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = IRQ_EN ? sw_changed_q : 1'b0;

endmodule
